sseg_score_driver: RTL
======================

SSEG_SCORE_DRIVER -- requirements
Module: sseg_score_driver

Interface
REQ-001 Parameter SCORE_W, default 10: width of the binary score input, legal range 4..14.
REQ-002 Parameter SCAN_DIV, default 50000: sys_clk cycles per digit slot (1 kHz per digit at 50 MHz), minimum 2.
REQ-003 Parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = show all four digits.
REQ-004 Port sys_clk, input, 1: 50 MHz system clock; the only clock in the block.
REQ-005 Port sys_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port score, input, SCORE_W: binary game score (tail count), quasi-static, synchronous to sys_clk.
REQ-007 Port sseg_a_to_dp, output, 8: segment drive, active-low; bit0=a ... bit6=g, bit7=dp.
REQ-008 Port sseg_an, output, 4: digit enables, active-low; bit0 = units digit, bit3 = thousands digit.
REQ-009 Port busy, output, 1: high while a binary-to-BCD conversion is in progress.

Function
REQ-010 Every output SHALL be driven from a register; no combinational path from score to any output.
REQ-011 The converter FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE: if score != last_conv (last converted value), latch score, clear the BCD shift register, go to SHIFT, and set busy the next cycle.
REQ-013 SHIFT SHALL run a double-dabble step (add 3 to any BCD nibble >= 5, then shift left 1) once per cycle, for exactly SCORE_W cycles.
REQ-014 DONE SHALL copy the four BCD nibbles into the display register, update last_conv, clear busy, and return to IDLE; latency from score change to display update is SCORE_W+2 cycles.
REQ-015 A score change during SHIFT or DONE SHALL NOT abort the conversion; the IDLE compare picks it up in the cycle after DONE.
REQ-016 A latched value above 9999 SHALL saturate to 9999 before conversion.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at each wrap the digit index (2 bits) SHALL advance 0->1->2->3->0.
REQ-018 Exactly one sseg_an bit SHALL be low at any time after the first post-reset wrap; the low bit equals the digit index.
REQ-019 sseg_a_to_dp SHALL carry the standard 7-segment glyph for the selected nibble (0-9); dp (bit7) is always 1 (off).
REQ-020 With BLANK_LZ=1, a digit SHALL be blanked (all segments 1) when it and every higher digit are zero; the units digit is never blanked.
REQ-021 The anode and segment registers SHALL change in the same cycle, one cycle after the counter wrap.

Reset
REQ-022 While sys_rst_n is low: sseg_an = 4'b1111, sseg_a_to_dp = 8'hFF, busy = 0, FSM = IDLE, scan counter = 0, digit index = 0, display register = 0, last_conv = 0.
REQ-023 A reset asserted mid-conversion SHALL discard the partial result; the display register keeps nothing from it.
REQ-024 After release with score = 0, no conversion starts, and the first wrap shows "0" on digit 0 only (BLANK_LZ=1).

Structure
REQ-025 Package sseg_pkg SHALL hold the FSM state encoding, the 7-segment glyph table for 0-9, the blank glyph constant, and the default SCAN_DIV.
REQ-026 The double-dabble datapath plus its FSM SHALL be a separate sub-module, bin2bcd_seq; sseg_score_driver instantiates it and holds the scan counter, the digit mux and the glyph lookup.

Verification (SCAN_DIV=4 in the bench)
REQ-027 Reset, score=0 -> sseg_an=1111 and seg=FF during reset; after the first wrap, an=1110 and seg=C0 ("0"); digits 1-3 read FF.
REQ-028 score 0->1023 -> busy high for SCORE_W+1 cycles; display reads 1,0,2,3 at digits 3..0 exactly SCORE_W+2 cycles after the change.
REQ-029 score changes 5->47 during SHIFT -> first result shows 5; a second conversion follows immediately and shows 47; no glitch value appears.
REQ-030 SCORE_W=14, score=12000 -> display 9999.
REQ-031 Free-run 40 cycles -> anode pattern 1110,1101,1011,0111 repeats with a period of 16 cycles; never two bits low.
REQ-032 Reset pulsed 3 cycles into a conversion of 999 -> after release, display returns to 0 and a fresh conversion of 999 completes in SCORE_W+2 cycles.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared definitions for the score display driver.
//   conv_state_e : converter FSM encoding (IDLE/SHIFT/DONE)
//   SEG_GLYPH    : active-low 7-segment glyphs for 0-9, bit0=a .. bit6=g, bit7=dp
//   SEG_BLANK    : all segments off
//   DEF_SCAN_DIV : default cycles per digit slot (1 kHz/digit at 50 MHz)
package sseg_pkg;

  localparam int unsigned DEF_SCAN_DIV = 50000;
  localparam int unsigned BCD_MAX      = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the glyph for digit n; dp (bit7) kept high everywhere.
  localparam logic [9:0][7:0] SEG_GLYPH = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Non-decimal nibbles cannot come out of the converter; show blank anyway.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] g;
    g = SEG_BLANK;
    if (nib <= 4'd9) g = SEG_GLYPH[nib];
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential double-dabble converter, one bit per cycle.
// Watches bin_i; whenever it differs from the last converted value it
// latches it (saturated to 9999), shifts BIN_W times, then publishes the
// four BCD nibbles on bcd_o.
//   clk_i  : clock
//   rst_ni : async active-low reset
//   bin_i  : binary input, quasi-static
//   busy_o : high while a conversion is in flight
//   bcd_o  : registered BCD result {thousands, hundreds, tens, units}
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int unsigned BIN_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic [15:0]      bcd_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;     // shifting operand
  logic [BIN_W-1:0] lat_q, lat_d;     // raw value being converted
  logic [BIN_W-1:0] last_q, last_d;   // raw value last published
  logic [15:0]      acc_q, acc_d;     // BCD shift register
  logic [15:0]      disp_q, disp_d;   // published result
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [15:0]      adj;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lat_d   = lat_q;
    last_d  = last_q;
    acc_d   = acc_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        // last_q holds the raw input, so a saturated value does not
        // retrigger forever.
        if (bin_i != last_q) begin
          lat_d   = bin_i;
          bin_d   = (32'(bin_i) > BCD_MAX) ? BIN_W'(BCD_MAX) : bin_i;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = {adj[14:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_d  = acc_q;
        last_d  = lat_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      lat_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign bcd_o  = disp_q;

endmodule

// File: rtl/sseg_score_driver.sv
// sseg_score_driver -- converts a binary score to BCD and scans it onto a
// 4-digit common-anode 7-segment display.
//   sys_clk      : system clock
//   sys_rst_n    : async active-low reset
//   score        : binary score, quasi-static
//   sseg_a_to_dp : active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
//   sseg_an      : active-low digit enables, bit0 = units
//   busy         : conversion in progress
module sseg_score_driver
  import sseg_pkg::*;
#(
  parameter int unsigned SCORE_W  = 10,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [SCORE_W-1:0] score,
  output logic [7:0]         sseg_a_to_dp,
  output logic [3:0]         sseg_an,
  output logic               busy
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  logic [15:0]       disp;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        dig_q, dig_d;
  logic              armed_q, armed_d;
  logic              tick_q, tick_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              wrap;
  logic [3:0]        lz;
  logic [3:0]        nib;
  logic              blank;

  bin2bcd_seq #(
    .BIN_W (SCORE_W)
  ) u_conv (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .bin_i  (score),
    .busy_o (busy),
    .bcd_o  (disp)
  );

  // lz[d]: digit d and everything above it are zero. Units never blank.
  assign lz[3] = (disp[15:12] == 4'd0);
  assign lz[2] = lz[3] && (disp[11:8] == 4'd0);
  assign lz[1] = lz[2] && (disp[7:4] == 4'd0);
  assign lz[0] = 1'b0;

  assign nib   = disp[{dig_q, 2'b00} +: 4];
  assign blank = BLANK_LZ && lz[dig_q];
  assign wrap  = (scan_q == SCAN_W'(SCAN_DIV - 1));

  // The first wrap after reset only arms the display so digit 0 is shown
  // first; later wraps advance the index. The anode/segment pair is loaded
  // one cycle after each wrap from the index in effect at that point.
  always_comb begin
    scan_d  = wrap ? '0 : scan_q + 1'b1;
    dig_d   = (wrap && armed_q) ? dig_q + 2'd1 : dig_q;
    armed_d = armed_q | wrap;
    tick_d  = wrap;
    an_d    = an_q;
    seg_d   = seg_q;
    if (tick_q) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = blank ? SEG_BLANK : seg_glyph(nib);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_q  <= '0;
      dig_q   <= '0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
    end else begin
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign sseg_an      = an_q;
  assign sseg_a_to_dp = seg_q;

endmodule
